// File: rtl/branch_unit_pkg.sv
// Shared opcode encodings for the branch/control-flow unit.
package branch_unit_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] op_t;

    typedef enum op_t {
        kNOP = 4'h0,
        kCMP = 4'h1,
        kBRR = 4'h2,
        kBRC = 4'h3,
        kCAL = 4'h4,
        kRET = 4'h5
    } opcode_e;

endpackage

// File: rtl/branch_unit_ret_stack.sv
// Return-address stack: synchronous push/pop, reset clears only the pointer.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = AW'(sp - PW'(1));
    assign full   = (sp == PW'(DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    // Entries are not reset; the pointer alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: compare flag, conditional/unconditional branches, CALL/RET and fetch squash.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned IW          = 9,
    parameter int unsigned OPW         = 4,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned BRC_ON_ZERO = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IW-1:0]     Instruction,
    input  logic              Valid,
    input  logic              ZERO,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] Target,
    output logic              branch_en,
    output logic [ADDR_W-1:0] branch_target,
    output logic              flush,
    output logic              zero_flag,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam logic TAKE_LEVEL = (BRC_ON_ZERO != 0);

    logic [OPW-1:0]    opcode;
    logic              ev;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              unused_operand_bits;

    assign opcode              = Instruction[IW-1 -: OPW];
    assign unused_operand_bits = ^Instruction[IW-OPW-1:0];
    assign ev                  = Valid & ~flush;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (PC + ADDR_W'(1)),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        branch_en     = 1'b0;
        branch_target = Target;
        push          = 1'b0;
        pop           = 1'b0;
        case (opcode)
            OPW'(kBRR): branch_en = ev;
            OPW'(kBRC): branch_en = ev & (zero_flag == TAKE_LEVEL);
            OPW'(kCAL): begin
                push      = ev & ~stack_full;
                branch_en = ev & ~stack_full;
            end
            OPW'(kRET): begin
                branch_target = stack_empty ? '0 : stack_top;
                pop           = ev & ~stack_empty;
                branch_en     = ev & ~stack_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            flush     <= 1'b0;
            zero_flag <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            flush <= branch_en;
            if (ev && opcode == OPW'(kCMP)) begin
                zero_flag <= ZERO;
            end
            if (ev && opcode == OPW'(kCAL) && stack_full) begin
                stack_ovf <= 1'b1;
            end
            if (ev && opcode == OPW'(kRET) && stack_empty) begin
                stack_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed vector bench for branch_unit (beq instance plus a bne instance).
module tb_branch_unit;
    import branch_unit_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [8:0] Instruction = '0;
    logic       Valid = 1'b0;
    logic       ZERO = 1'b0;
    logic [9:0] PC = '0;
    logic [9:0] Target = '0;

    logic       branch_en, flush, zero_flag, stack_ovf, stack_unf;
    logic [9:0] branch_target;
    logic       b_en, b_flush, b_flag, b_ovf, b_unf;
    logic [9:0] b_target;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0] op;
        logic       v;
        logic       z;
        logic [9:0] pc;
        logic [9:0] tgt;
        logic       en;
        logic [9:0] btgt;
        logic       chk_tgt;
        logic       fl;
        logic       fg;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vq[$];

    branch_unit #(.STACK_DEPTH(4), .BRC_ON_ZERO(1)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .Valid(Valid),
        .ZERO(ZERO), .PC(PC), .Target(Target),
        .branch_en(branch_en), .branch_target(branch_target), .flush(flush),
        .zero_flag(zero_flag), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    branch_unit #(.STACK_DEPTH(4), .BRC_ON_ZERO(0)) dut_bne (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .Valid(Valid),
        .ZERO(ZERO), .PC(PC), .Target(Target),
        .branch_en(b_en), .branch_target(b_target), .flush(b_flush),
        .zero_flag(b_flag), .stack_ovf(b_ovf), .stack_unf(b_unf)
    );

    always #5 Clk = ~Clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%03h want 0x%03h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic v, input logic z,
                       input logic [9:0] pc, input logic [9:0] tgt,
                       input logic en, input logic [9:0] btgt, input logic chk,
                       input logic fl, input logic fg, input logic ov, input logic un);
        vec_t r;
        r.op = op; r.v = v; r.z = z; r.pc = pc; r.tgt = tgt;
        r.en = en; r.btgt = btgt; r.chk_tgt = chk;
        r.fl = fl; r.fg = fg; r.ov = ov; r.un = un;
        vq.push_back(r);
    endtask

    // Drive at the falling edge and settle, so combinational outputs can be sampled.
    task automatic drive(input logic [3:0] op, input logic v, input logic z,
                         input logic [9:0] pc, input logic [9:0] tgt);
        @(negedge Clk);
        Instruction = {op, 5'b0};
        Valid = v;
        ZERO = z;
        PC = pc;
        Target = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        Instruction = '0;
        Valid = 1'b0;
        PC = '0;
        Target = '0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        // Table: op, valid, zero, pc, target | en, btgt, chk | flush, flag, ovf, unf after posedge
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 1, 0, 0, 0, 0);
        add(kCMP, 1, 1, 10'h001, 10'h000, 0, 10'h000, 0, 0, 1, 0, 0);
        add(kBRC, 1, 0, 10'h002, 10'h040, 1, 10'h040, 1, 1, 1, 0, 0);
        add(kNOP, 1, 0, 10'h003, 10'h000, 0, 10'h000, 0, 0, 1, 0, 0);
        add(kCMP, 1, 0, 10'h004, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kBRC, 1, 1, 10'h005, 10'h040, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h3FF, 10'h010, 1, 10'h010, 1, 1, 0, 0, 0);
        add(kNOP, 1, 0, 10'h010, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kRET, 1, 0, 10'h011, 10'h2EE, 1, 10'h000, 1, 1, 0, 0, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h100, 10'h200, 1, 10'h200, 1, 1, 0, 0, 0);
        add(kCAL, 1, 0, 10'h1AA, 10'h2AA, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h101, 10'h201, 1, 10'h201, 1, 1, 0, 0, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h102, 10'h202, 1, 10'h202, 1, 1, 0, 0, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h103, 10'h203, 1, 10'h203, 1, 1, 0, 0, 0);
        add(kRET, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 0, 0);
        add(kCAL, 1, 0, 10'h104, 10'h204, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 0, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 1, 0, 10'h000, 10'h000, 1, 10'h104, 1, 1, 0, 1, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 1, 0, 10'h000, 10'h000, 1, 10'h103, 1, 1, 0, 1, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 1, 0, 10'h000, 10'h000, 1, 10'h102, 1, 1, 0, 1, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 1, 0, 10'h000, 10'h000, 1, 10'h101, 1, 1, 0, 1, 0);
        add(kNOP, 1, 0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 1, 0);
        add(kRET, 1, 0, 10'h000, 10'h155, 0, 10'h000, 1, 0, 0, 1, 1);
        add(kCMP, 1, 1, 10'h020, 10'h000, 0, 10'h000, 0, 0, 1, 1, 1);
        add(kBRC, 1, 0, 10'h021, 10'h055, 1, 10'h055, 1, 1, 1, 1, 1);
        add(kNOP, 1, 0, 10'h055, 10'h000, 0, 10'h000, 0, 0, 1, 1, 1);
        add(kBRR, 1, 0, 10'h056, 10'h077, 1, 10'h077, 1, 1, 1, 1, 1);
        add(kBRR, 1, 0, 10'h057, 10'h088, 0, 10'h000, 0, 0, 1, 1, 1);
        add(4'hF, 1, 1, 10'h077, 10'h099, 0, 10'h099, 1, 0, 1, 1, 1);
        add(kBRR, 0, 0, 10'h078, 10'h0AA, 0, 10'h000, 0, 0, 1, 1, 1);

        // Reset state
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check1("rst branch_en", branch_en, 1'b0);
        check10("rst branch_target", branch_target, 10'h000);
        check1("rst flush", flush, 1'b0);
        check1("rst zero_flag", zero_flag, 1'b0);
        check1("rst stack_ovf", stack_ovf, 1'b0);
        check1("rst stack_unf", stack_unf, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].op, vq[i].v, vq[i].z, vq[i].pc, vq[i].tgt);
            check1($sformatf("v%0d branch_en", i), branch_en, vq[i].en);
            if (vq[i].chk_tgt)
                check10($sformatf("v%0d branch_target", i), branch_target, vq[i].btgt);
            tick();
            check1($sformatf("v%0d flush", i), flush, vq[i].fl);
            check1($sformatf("v%0d zero_flag", i), zero_flag, vq[i].fg);
            check1($sformatf("v%0d stack_ovf", i), stack_ovf, vq[i].ov);
            check1($sformatf("v%0d stack_unf", i), stack_unf, vq[i].un);
        end

        // Reset mid-stream with two stacked entries and flush pending
        do_reset();
        drive(kCMP, 1, 1, 10'h000, 10'h000); tick();
        drive(kCAL, 1, 0, 10'h050, 10'h060); tick();
        drive(kNOP, 1, 0, 10'h060, 10'h000); tick();
        drive(kCAL, 1, 0, 10'h051, 10'h061); tick();
        check1("mid pre-reset flush", flush, 1'b1);
        check1("mid pre-reset zero_flag", zero_flag, 1'b1);
        @(negedge Clk);
        Reset = 1'b0;
        Instruction = '0;
        Valid = 1'b1;
        PC = '0;
        Target = '0;
        tick();
        check1("mid branch_en", branch_en, 1'b0);
        check10("mid branch_target", branch_target, 10'h000);
        check1("mid flush", flush, 1'b0);
        check1("mid zero_flag", zero_flag, 1'b0);
        check1("mid stack_ovf", stack_ovf, 1'b0);
        check1("mid stack_unf", stack_unf, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        drive(kRET, 1, 0, 10'h000, 10'h3AA);
        check1("mid ret-after-reset branch_en", branch_en, 1'b0);
        check10("mid ret-after-reset target", branch_target, 10'h000);
        tick();
        check1("mid ret-after-reset stack_unf", stack_unf, 1'b1);

        // bne instance against the same CMP/BRC stimulus
        do_reset();
        drive(kCMP, 1, 0, 10'h000, 10'h000); tick();
        drive(kBRC, 1, 1, 10'h001, 10'h123);
        check1("bne z0 branch_en", b_en, 1'b1);
        check10("bne z0 branch_target", b_target, 10'h123);
        check1("beq z0 branch_en", branch_en, 1'b0);
        tick();
        check1("bne z0 flush", b_flush, 1'b1);
        check1("beq z0 flush", flush, 1'b0);
        drive(kNOP, 1, 0, 10'h123, 10'h000); tick();
        drive(kCMP, 1, 1, 10'h124, 10'h000); tick();
        drive(kBRC, 1, 0, 10'h125, 10'h133);
        check1("bne z1 branch_en", b_en, 1'b0);
        check1("beq z1 branch_en", branch_en, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
